// File: rtl/sdram_auto_refresh_pkg.sv
// Shared SDRAM constants for the refresh engine: command encodings, default
// timing and address width, plus the refresh FSM state type.
package sdram_auto_refresh_pkg;

    // {Cs_n, Ras_n, Cas_n, We_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;

    localparam int ASIZE_DEF      = 13;
    localparam int TRP_DEF        = 2;
    localparam int TRFC_DEF       = 7;
    localparam int REF_PERIOD_DEF = 780;
    localparam int AREF_NUM_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECH,
        ST_WAIT_RP,
        ST_AREF,
        ST_WAIT_RFC,
        ST_DONE
    } ref_state_e;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_auto_refresh.sv
// Periodic auto-refresh engine: interval timer, arbiter request/grant, and a
// PRECHARGE-all + AUTO REFRESH burst with tRP/tRFC spacing. Outputs registered.
module sdram_auto_refresh
    import sdram_auto_refresh_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int TRP        = TRP_DEF,
    parameter int TRFC       = TRFC_DEF,
    parameter int AREF_NUM   = AREF_NUM_DEF,
    parameter int ASIZE      = ASIZE_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Init_done,
    input  logic             Ref_en,
    output logic             Ref_req,
    output logic             Ref_busy,
    output logic             Ref_end,
    output logic [3:0]       Command,
    output logic [ASIZE-1:0] Saddr,
    output logic [2:0]       Ref_state
);

    localparam int TMR_W = cnt_width(REF_PERIOD);
    localparam int CNT_W = cnt_width((TRP > TRFC) ? TRP : TRFC);
    localparam int AN_W  = cnt_width(AREF_NUM + 1);

    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(REF_PERIOD - 1);
    localparam logic [CNT_W-1:0] RP_LAST    = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] RFC_LAST   = CNT_W'(TRFC - 1);
    localparam logic [AN_W-1:0]  AREF_TOTAL = AN_W'(AREF_NUM);

    ref_state_e       state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [AN_W-1:0]  aref_cnt, aref_n;
    logic             pending, pending_n;
    logic             req_n, busy_n, end_n;
    logic [3:0]       cmd_n;
    logic [ASIZE-1:0] saddr_n;
    logic             expiry, grant, expiry_busy;

    assign expiry      = Init_done && (timer == TMR_LAST);
    assign grant       = (state == ST_IDLE) && Ref_req && Ref_en;
    // The DONE cycle is excluded: a request raised there lands right after it.
    assign expiry_busy = ((state != ST_IDLE) && (state != ST_DONE)) || grant;
    assign Ref_state   = state;

    always_comb begin
        state_n = state;
        aref_n  = aref_cnt;
        cnt_n   = '0;
        case (state)
            ST_IDLE:     if (grant) state_n = ST_PRECH;
            ST_PRECH:    state_n = (TRP == 1) ? ST_AREF : ST_WAIT_RP;
            ST_WAIT_RP:  if (cnt == RP_LAST) state_n = ST_AREF;
            ST_AREF: begin
                if (TRFC == 1)
                    state_n = (aref_cnt == AREF_TOTAL) ? ST_DONE : ST_AREF;
                else
                    state_n = ST_WAIT_RFC;
            end
            ST_WAIT_RFC: begin
                if (cnt == RFC_LAST)
                    state_n = (aref_cnt == AREF_TOTAL) ? ST_DONE : ST_AREF;
            end
            ST_DONE:     state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase

        // cnt tracks cycles since the last command; aref_cnt includes the current AREF.
        if ((state_n == ST_WAIT_RP) || (state_n == ST_WAIT_RFC))
            cnt_n = cnt + 1'b1;
        if (state_n == ST_PRECH)
            aref_n = '0;
        else if (state_n == ST_AREF)
            aref_n = aref_cnt + 1'b1;

        cmd_n   = CMD_NOP;
        saddr_n = '0;
        case (state_n)
            ST_PRECH: begin
                cmd_n       = CMD_PRECHARGE;
                saddr_n[10] = 1'b1;
            end
            ST_AREF:  cmd_n = CMD_AREF;
            default:  cmd_n = CMD_NOP;
        endcase
        busy_n = (state_n != ST_IDLE);
        end_n  = (state_n == ST_DONE);
    end

    always_comb begin
        timer_n   = '0;
        req_n     = Ref_req;
        pending_n = pending;
        if (Init_done)
            timer_n = (timer == TMR_LAST) ? '0 : timer + 1'b1;
        if (grant)
            req_n = 1'b0;
        if (expiry) begin
            if (expiry_busy)
                pending_n = 1'b1;
            else
                req_n = 1'b1;
        end
        if (state == ST_DONE) begin
            if (pending)
                req_n = 1'b1;
            pending_n = 1'b0;
        end
        if (!Init_done)
            pending_n = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            cnt      <= '0;
            aref_cnt <= '0;
            pending  <= 1'b0;
            Ref_req  <= 1'b0;
            Ref_busy <= 1'b0;
            Ref_end  <= 1'b0;
            Command  <= CMD_NOP;
            Saddr    <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            cnt      <= cnt_n;
            aref_cnt <= aref_n;
            pending  <= pending_n;
            Ref_req  <= req_n;
            Ref_busy <= busy_n;
            Ref_end  <= end_n;
            Command  <= cmd_n;
            Saddr    <= saddr_n;
        end
    end

endmodule
